// File: rtl/mdu_pkg.sv
// Shared types, encodings and helpers for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned MUL_LAT_DEF    = 2;
  localparam int unsigned DIV_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } mdu_state_e;

  // Operation captured at accept time and held for the whole sequence.
  typedef struct packed {
    mdu_op_e             op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } mdu_req_t;

  function automatic logic op_signed(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(mdu_op_e op);
    return op[1];
  endfunction

  // Absolute value when the operand is treated as signed, else pass-through.
  function automatic logic [DATA_W-1:0] magnitude(logic [DATA_W-1:0] x, logic sgn);
    return (sgn && x[DATA_W-1]) ? DATA_W'(-x) : x;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage <-> multiply/divide unit connection.
interface mdu_if;
  import mdu_pkg::*;

  logic              start_i;
  mdu_op_e           op_i;
  logic [DATA_W-1:0] src_a_i;
  logic [DATA_W-1:0] src_b_i;
  logic              flush_i;
  logic              stall_o;
  logic              busy_o;
  logic              hilo_we_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, flush_i,
    input  stall_o, busy_o, hilo_we_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, flush_i,
    output stall_o, busy_o, hilo_we_o, hi_o, lo_o
  );

endinterface

// File: rtl/div_radix2_core.sv
// Unsigned restoring divider: one quotient bit per cycle after a load.
// Outputs show the result of the step taken in the current cycle, so the
// final quotient/remainder are available while done_c is high.
module div_radix2_core
  import mdu_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done_c,
  output logic [DATA_W-1:0] quotient_c,
  output logic [DATA_W-1:0] remainder_c
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q;
  logic [DATA_W:0]   shifted;
  logic              ge;

  // Shift-subtract step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted     = {rem_q, quo_q[DATA_W-1]};
    ge          = shifted >= {1'b0, dvs_q};
    remainder_c = ge ? DATA_W'(shifted - {1'b0, dvs_q}) : shifted[DATA_W-1:0];
    quotient_c  = {quo_q[DATA_W-2:0], ge};
    done_c      = run_q && (cnt_q == CNT_W'(DIV_CYCLES - 1));
  end

  // Load operands on start, then iterate until the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= remainder_c;
      quo_q <= quotient_c;
      cnt_q <= cnt_q + 1'b1;
      if (done_c) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer in EX: stalls the pipe while busy, then issues
// one HI/LO write. A flush cancels the operation at any point.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT    = MUL_LAT_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mdu_state_e         state_q;
  mdu_state_e         state_d;
  mdu_req_t           req_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  hi_q;
  logic [DATA_W-1:0]  lo_q;
  logic [DATA_W-1:0]  hi_prev_q;
  logic [DATA_W-1:0]  lo_prev_q;

  logic               accept_c;
  logic               mul_last_c;
  logic               div_last_c;
  logic               load_c;
  logic               stall_c;
  logic               busy_c;
  logic               hilo_we_c;

  logic signed [DATA_W:0] mul_a;
  logic signed [DATA_W:0] mul_b;
  logic [2*DATA_W-1:0]    product;
  logic                   q_neg;
  logic                   r_neg;
  logic [DATA_W-1:0]      res_hi;
  logic [DATA_W-1:0]      res_lo;

  logic                   div_start;
  logic                   div_done_c;
  logic [DATA_W-1:0]      div_quo_c;
  logic [DATA_W-1:0]      div_rem_c;

  assign div_start = accept_c && op_is_div(bus.op_i);

  div_radix2_core #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start),
    .dividend    (magnitude(bus.src_a_i, op_signed(bus.op_i))),
    .divisor     (magnitude(bus.src_b_i, op_signed(bus.op_i))),
    .done_c      (div_done_c),
    .quotient_c  (div_quo_c),
    .remainder_c (div_rem_c)
  );

  // Result formation: 33-bit extended multiply, or sign fix-up of the divider.
  always_comb begin
    mul_a   = {op_signed(req_q.op) & req_q.a[DATA_W-1], req_q.a};
    mul_b   = {op_signed(req_q.op) & req_q.b[DATA_W-1], req_q.b};
    product = (2*DATA_W)'(mul_a * mul_b);
    q_neg   = op_signed(req_q.op) && (req_q.a[DATA_W-1] ^ req_q.b[DATA_W-1]);
    r_neg   = op_signed(req_q.op) && req_q.a[DATA_W-1];
    res_hi  = product[2*DATA_W-1:DATA_W];
    res_lo  = product[DATA_W-1:0];
    if (op_is_div(req_q.op)) begin
      if (req_q.b == '0) begin
        res_hi = req_q.a;
        res_lo = '1;
      end else begin
        res_lo = q_neg ? DATA_W'(-div_quo_c) : div_quo_c;
        res_hi = r_neg ? DATA_W'(-div_rem_c) : div_rem_c;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; flush always returns to IDLE.
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    mul_last_c = 1'b0;
    div_last_c = 1'b0;
    stall_c    = 1'b0;
    busy_c     = 1'b0;
    hilo_we_c  = 1'b0;
    case (state_q)
      IDLE: begin
        accept_c = bus.start_i && !bus.flush_i;
        stall_c  = accept_c;
        if (accept_c) begin
          state_d = op_is_div(bus.op_i) ? DIV : MUL;
        end
      end
      MUL: begin
        busy_c     = 1'b1;
        stall_c    = 1'b1;
        mul_last_c = (cnt_q == CNT_W'(MUL_LAT - 1));
        if (mul_last_c) begin
          state_d = DONE;
        end
      end
      DIV: begin
        busy_c     = 1'b1;
        stall_c    = 1'b1;
        div_last_c = div_done_c;
        if (div_last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        hilo_we_c = !bus.flush_i;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = IDLE;
    end
  end

  assign load_c = (mul_last_c || div_last_c) && !bus.flush_i;

  // Operand capture, multiply latency counter and HI/LO result registers.
  // The previous result is kept so a flush during DONE can take back the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_prev_q <= '0;
      lo_prev_q <= '0;
    end else begin
      if (accept_c) begin
        req_q <= '{op: bus.op_i, a: bus.src_a_i, b: bus.src_b_i};
        cnt_q <= '0;
      end else if (state_q == MUL) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (load_c) begin
        hi_prev_q <= hi_q;
        lo_prev_q <= lo_q;
        hi_q      <= res_hi;
        lo_q      <= res_lo;
      end else if ((state_q == DONE) && bus.flush_i) begin
        hi_q <= hi_prev_q;
        lo_q <= lo_prev_q;
      end
    end
  end

  assign bus.stall_o   = stall_c;
  assign bus.busy_o    = busy_c;
  assign bus.hilo_we_o = hilo_we_c;
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vector table, flush/reset sequences and
// randomized operations against an arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int unsigned MUL_LAT    = 2;
  localparam int unsigned DIV_CYCLES = 32;
  localparam int          NVEC       = 10;

  typedef struct {
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  vec_t        vecs [NVEC];

  mdu_if bus ();

  mdu_ctrl #(
    .MUL_LAT    (MUL_LAT),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Architectural result {HI, LO} computed with wide integer arithmetic.
  function automatic logic [63:0] ref_model(mdu_op_e op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == MDU_MULT) return 64'(sa * sb);
    if (op == MDU_MULTU) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == MDU_DIV) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = longint'(ua / ub);
      r = longint'(ua % ub);
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Present an op with start held until its write; check stall length and result.
  task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
    int stalls;
    int exp_stalls;
    bit got;
    stalls = 0;
    got = 1'b0;
    exp_stalls = ((op == MDU_DIV || op == MDU_DIVU) ? int'(DIV_CYCLES) : int'(MUL_LAT)) + 1;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src_a_i = a;
    bus.src_b_i = b;
    bus.flush_i = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus.hilo_we_o === 1'b1) begin
        got = 1'b1;
        chk({nm, " hi"}, bus.hi_o, exp_hi);
        chk({nm, " lo"}, bus.lo_o, exp_lo);
        chk({nm, " stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        chk({nm, " busy_in_done"}, 32'(bus.busy_o), 32'd0);
      end else if (bus.stall_o === 1'b1) begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no hilo_we after %0d stall cycles", nm, stalls);
    end
    bus.start_i = 1'b0;
    last_hi = exp_hi;
    last_lo = exp_lo;
  endtask

  // Idle for n cycles and require that no HI/LO write appears.
  task automatic watch_no_we(input int n, input string nm);
    int cnt;
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (bus.hilo_we_o !== 1'b0) cnt++;
      @(posedge clk);
      #1;
    end
    chk({nm, " spurious_we"}, 32'(cnt), 32'd0);
  endtask

  initial begin
    mdu_op_e     rop;
    logic [31:0] ra, rb;
    logic [63:0] rexp;

    vecs[0] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{MDU_DIVU,  32'd7,         32'd2,        32'd1,         32'd3};
    vecs[4] = '{MDU_DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{MDU_DIV,   32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF};
    vecs[7] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9] = '{MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = MDU_MULT;
    bus.src_a_i = '0;
    bus.src_b_i = '0;
    bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset stall", 32'(bus.stall_o), 32'd0);
    chk("reset busy", 32'(bus.busy_o), 32'd0);
    chk("reset we", 32'(bus.hilo_we_o), 32'd0);
    chk("reset hi", bus.hi_o, 32'd0);
    chk("reset lo", bus.lo_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
    end

    // Back-to-back: DIVU presented in the IDLE cycle right after the MULT write.
    run_op(MDU_MULT, 32'h0000_1234, 32'h0000_0010, 32'd0, 32'h0001_2340, "b2b mult");
    run_op(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "b2b divu");

    // Flush on divide iteration 10.
    bus.start_i = 1'b1;
    bus.op_i    = MDU_DIV;
    bus.src_a_i = 32'd1000;
    bus.src_b_i = 32'd3;
    @(posedge clk);
    #1;
    repeat (9) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("flush_div stall_during", 32'(bus.stall_o), 32'd1);
    chk("flush_div we_during", 32'(bus.hilo_we_o), 32'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_div stall_after", 32'(bus.stall_o), 32'd0);
    chk("flush_div busy_after", 32'(bus.busy_o), 32'd0);
    chk("flush_div hi_kept", bus.hi_o, last_hi);
    chk("flush_div lo_kept", bus.lo_o, last_lo);
    watch_no_we(40, "flush_div");
    chk("flush_div hi_late", bus.hi_o, last_hi);

    // Flush outranks start in IDLE.
    bus.start_i = 1'b1;
    bus.op_i    = MDU_MULT;
    bus.src_a_i = 32'd9;
    bus.src_b_i = 32'd9;
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_idle stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle busy", 32'(bus.busy_o), 32'd0);
    watch_no_we(6, "flush_idle");

    // Flush landing in DONE suppresses the write and keeps the old result.
    bus.start_i = 1'b1;
    bus.op_i    = MDU_MULT;
    bus.src_a_i = 32'd3;
    bus.src_b_i = 32'd4;
    repeat (MUL_LAT + 1) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_done we", 32'(bus.hilo_we_o), 32'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("flush_done hi_kept", bus.hi_o, last_hi);
    chk("flush_done lo_kept", bus.lo_o, last_lo);
    watch_no_we(6, "flush_done");

    // Reset in the middle of a divide.
    bus.start_i = 1'b1;
    bus.op_i    = MDU_DIV;
    bus.src_a_i = 32'd50;
    bus.src_b_i = 32'd7;
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("rst_div stall_before", 32'(bus.stall_o), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_div stall", 32'(bus.stall_o), 32'd0);
    chk("rst_div busy", 32'(bus.busy_o), 32'd0);
    chk("rst_div hi", bus.hi_o, 32'd0);
    chk("rst_div lo", bus.lo_o, 32'd0);
    last_hi = '0;
    last_lo = '0;
    watch_no_we(40, "rst_div");

    // Randomized operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      rop = mdu_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 100));
      rexp = ref_model(rop, ra, rb);
      run_op(rop, ra, rb, rexp[63:32], rexp[31:0], $sformatf("rnd%0d op%0d", i, rop));
    end

    // Result persists while idle.
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("hold hi", bus.hi_o, last_hi);
    chk("hold lo", bus.lo_o, last_lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
